// File: rtl/alu_operand_ctrl_if.sv
// Operand/result bundle between the ALU control stage,
// its bus master and the combinational ALU.
interface alu_operand_ctrl_if;
  logic [3:0] data_in;
  logic       load_a;
  logic       load_b;
  logic [2:0] func_in;
  logic       go;
  logic       acc_en;
  logic [7:0] alu_result;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [2:0] func_out;
  logic [7:0] result_reg;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] op_count;

  modport master (
    output data_in, load_a, load_b,
    output func_in, go, acc_en,
    output alu_result,
    input  a_out, b_out, func_out,
    input  result_reg, busy, done,
    input  err, op_count
  );

  modport slave (
    input  data_in, load_a, load_b,
    input  func_in, go, acc_en,
    input  alu_result,
    output a_out, b_out, func_out,
    output result_reg, busy, done,
    output err, op_count
  );
endinterface

// File: rtl/alu_operand_ctrl.sv
// Operand capture, settle window and result
// register around the 4-bit ALU.
module alu_operand_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  alu_operand_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [3:0] LAST =
    4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic       la_q, lb_q, go_q;
  logic       la_rise, lb_rise, go_rise;
  logic       ld_a, ld_b, start, capture;
  logic [3:0] cnt;
  logic       last;

  logic [3:0] a_r, b_r;
  logic [2:0] func_r;
  logic [7:0] res_r, cnt_ops;
  logic       busy_r, done_r, err_r;

  assign la_rise = bus.load_a & ~la_q;
  assign lb_rise = bus.load_b & ~lb_q;
  assign go_rise = bus.go & ~go_q;
  assign last    = (cnt == LAST);

  // history tracks inputs in every state so
  // edges seen while busy are dropped, not queued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      la_q <= 1'b0;
      lb_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      la_q <= bus.load_a;
      lb_q <= bus.load_b;
      go_q <= bus.go;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go_rise) state_nx = ISSUE;
      ISSUE:   if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    start   = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        ld_a  = la_rise;
        ld_b  = lb_rise;
        start = go_rise;
      end
      ISSUE:   capture = last;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r     <= '0;
      b_r     <= '0;
      func_r  <= '0;
      err_r   <= 1'b0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      res_r   <= '0;
      cnt_ops <= '0;
    end else begin
      done_r <= capture;
      if (ld_a) a_r <= bus.data_in;
      // accumulate feedback wins over a load_b edge
      if (start && bus.acc_en)
        b_r <= res_r[3:0];
      else if (ld_b)
        b_r <= bus.data_in;
      if (start) begin
        func_r <= bus.func_in;
        err_r  <= (bus.func_in >= 3'b110);
        cnt    <= '0;
        busy_r <= 1'b1;
      end else if (state == ISSUE) begin
        cnt <= cnt + 4'd1;
      end
      if (capture) begin
        res_r   <= bus.alu_result;
        busy_r  <= 1'b0;
        cnt_ops <= cnt_ops + 8'd1;
      end
    end
  end

  assign bus.a_out      = a_r;
  assign bus.b_out      = b_r;
  assign bus.func_out   = func_r;
  assign bus.result_reg = res_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.op_count   = cnt_ops;

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed bench for alu_operand_ctrl with a
// behavioural 4-bit ALU on the result input.
module tb_alu_operand_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  alu_operand_ctrl_if ifc ();

  alu_operand_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    unique case (ifc.func_out)
      3'b000:  ifc.alu_result = {4'h0, ifc.a_out & ifc.b_out};
      3'b001:  ifc.alu_result = 8'(ifc.a_out) + 8'(ifc.b_out);
      3'b010:  ifc.alu_result = 8'(ifc.a_out) - 8'(ifc.b_out);
      3'b011:  ifc.alu_result = {4'h0, ifc.a_out | ifc.b_out};
      3'b100:  ifc.alu_result = {4'h0, ifc.a_out ^ ifc.b_out};
      3'b101:  ifc.alu_result = {ifc.a_out, ifc.b_out};
      default: ifc.alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic pulse_a(input logic [3:0] d);
    @(negedge clk);
    ifc.data_in = d;
    ifc.load_a = 1'b1;
    @(negedge clk);
    ifc.load_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [3:0] d);
    @(negedge clk);
    ifc.data_in = d;
    ifc.load_b = 1'b1;
    @(negedge clk);
    ifc.load_b = 1'b0;
  endtask

  // waits (bounded) for done, counting busy cycles
  task automatic wait_done(output int bc,
                           output bit ok);
    bc = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ifc.done) ok = 1'b1;
      else begin
        if (ifc.busy) bc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic go_pulse(input logic [2:0] f,
                          input logic acc);
    @(negedge clk);
    ifc.func_in = f;
    ifc.acc_en = acc;
    ifc.go = 1'b1;
    @(negedge clk);
    ifc.go = 1'b0;
    ifc.acc_en = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] f,
                        input logic acc,
                        input logic [7:0] e_res,
                        input logic e_err,
                        input logic [7:0] e_cnt);
    int bc;
    bit ok;
    go_pulse(f, acc);
    wait_done(bc, ok);
    chk({tag, "_done_seen"}, 32'(ok), 1);
    chk({tag, "_busy_cyc"}, bc, 2);
    chk({tag, "_result"}, ifc.result_reg, e_res);
    chk({tag, "_err"}, ifc.err, e_err);
    chk({tag, "_opcnt"}, ifc.op_count, e_cnt);
    @(negedge clk);
    chk({tag, "_done_fall"}, ifc.done, 0);
  endtask

  initial begin
    int  bc;
    bit  ok;
    int  dn;
    ifc.data_in = '0;
    ifc.load_a  = 1'b0;
    ifc.load_b  = 1'b0;
    ifc.func_in = '0;
    ifc.go      = 1'b0;
    ifc.acc_en  = 1'b0;

    #12;
    chk("rst_a", ifc.a_out, 0);
    chk("rst_b", ifc.b_out, 0);
    chk("rst_func", ifc.func_out, 0);
    chk("rst_res", ifc.result_reg, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_cnt", ifc.op_count, 0);
    @(negedge clk);
    reset_n = 1'b1;

    pulse_a(4'h3);
    pulse_b(4'h5);
    chk("ld_a", ifc.a_out, 3);
    chk("ld_b", ifc.b_out, 5);
    run_op("add", 3'b001, 1'b0, 8'h08, 1'b0, 8'd1);
    pulse_a(4'hA);
    pulse_b(4'h3);
    run_op("cat", 3'b101, 1'b0, 8'hA3, 1'b0, 8'd2);

    pulse_a(4'h3);
    pulse_b(4'h5);
    run_op("add2", 3'b001, 1'b0, 8'h08, 1'b0, 8'd3);
    pulse_a(4'h1);
    run_op("acc1", 3'b001, 1'b1, 8'h09, 1'b0, 8'd4);
    chk("acc1_b", ifc.b_out, 8);
    run_op("acc2", 3'b001, 1'b1, 8'h0A, 1'b0, 8'd5);
    chk("acc2_b", ifc.b_out, 9);
    run_op("acc3", 3'b001, 1'b1, 8'h0B, 1'b0, 8'd6);
    chk("acc3_b", ifc.b_out, 4'hA);

    pulse_a(4'h2);
    pulse_b(4'h2);
    @(negedge clk);
    ifc.func_in = 3'b001;
    ifc.go = 1'b1;
    @(negedge clk);
    ifc.go = 1'b0;
    chk("lock_busy", ifc.busy, 1);
    ifc.data_in = 4'hF;
    ifc.load_a = 1'b1;
    ifc.go = 1'b1;
    @(negedge clk);
    ifc.load_a = 1'b0;
    ifc.go = 1'b0;
    wait_done(bc, ok);
    chk("lock_done_seen", 32'(ok), 1);
    chk("lock_res", ifc.result_reg, 8'h04);
    chk("lock_a", ifc.a_out, 2);
    chk("lock_cnt", ifc.op_count, 7);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.done) dn++;
    end
    chk("lock_extra_done", dn, 0);
    chk("lock_idle", ifc.busy, 0);
    chk("lock_cnt2", ifc.op_count, 7);

    run_op("inv", 3'b110, 1'b0, 8'h00, 1'b1, 8'd8);
    run_op("and", 3'b000, 1'b0, 8'h02, 1'b0, 8'd9);

    go_pulse(3'b001, 1'b0);
    chk("mid_busy", ifc.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_busy0", ifc.busy, 0);
    chk("mid_done0", ifc.done, 0);
    chk("mid_res0", ifc.result_reg, 0);
    chk("mid_a0", ifc.a_out, 0);
    chk("mid_b0", ifc.b_out, 0);
    chk("mid_cnt0", ifc.op_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) dn++;
    end
    chk("mid_no_done", dn, 0);
    chk("mid_cnt_hold", ifc.op_count, 0);

    pulse_a(4'h1);
    pulse_b(4'h1);
    for (int k = 0; k < 255; k++) begin
      go_pulse(3'b001, 1'b0);
      wait_done(bc, ok);
      if (!ok) chk("wrap_timeout", 32'(ok), 1);
    end
    chk("pre_wrap", ifc.op_count, 255);
    go_pulse(3'b001, 1'b0);
    wait_done(bc, ok);
    chk("wrap_done_seen", 32'(ok), 1);
    chk("wrap_cnt", ifc.op_count, 0);
    chk("wrap_done", ifc.done, 1);
    ifc.func_in = 3'b101;
    ifc.go = 1'b1;
    @(negedge clk);
    ifc.go = 1'b0;
    chk("b2b_busy", ifc.busy, 1);
    chk("b2b_done_fall", ifc.done, 0);
    wait_done(bc, ok);
    chk("b2b_done_seen", 32'(ok), 1);
    chk("b2b_res", ifc.result_reg, 8'h11);
    chk("b2b_cnt", ifc.op_count, 1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
